bit_population_counter_pipe: RTL and testbench

Parametrised, fully pipelined population counter with valid/ready flow control on both sides and a per-beat ones/zeros mode. First stage counts bits per CHUNK_W slice; a registered binary adder tree then reduces the chunk counts, one tree level per stage. Sits in streaming datapaths where the downstream consumer can stall, so the block must absorb and hold in-flight beats.

---
 rtl/bit_population_counter_pipe.sv | 161 ++++++++++++++++
 tb/tb_bit_population_counter_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_population_counter_pipe.sv
// bit_population_counter_pipe
// Pipelined population counter with valid/ready flow control on both sides.
// Stage 0 counts ones (or zeros, per beat) in each CHUNK_W slice. Each later
// stage adds the previous level's counts in pairs until one count remains.
// Every stage holds its own valid flag and stalls independently, so bubbles
// collapse and a stalled output keeps the whole pipeline full.
// Optional feature macro: BPC_STATS_EN adds output-transfer statistics ports.
module bit_population_counter_pipe #(
    parameter int DATA_W  = 16,
    parameter int CHUNK_W = 4,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              mode_i,
    input  logic              data_val_i,
    output logic              data_ready_o,
    output logic [CNT_W-1:0]  data_o,
    output logic              data_val_o,
    input  logic              data_ready_i
`ifdef BPC_STATS_EN
    ,
    output logic [31:0]       stat_beats_o,
    output logic [CNT_W-1:0]  stat_max_o
`endif
);

    localparam int N_CHUNK  = DATA_W / CHUNK_W;
    localparam int TREE_LVL = $clog2(N_CHUNK);
    localparam int L        = 1 + TREE_LVL;

    // Number of entries held at a given tree level (odd counts round up).
    function automatic int n_at(input int lvl);
        int n;
        n = N_CHUNK;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Index of the first entry of a level in the flat entry array.
    function automatic int off_at(input int lvl);
        int o;
        o = 0;
        for (int i = 0; i < lvl; i++) o += n_at(i);
        return o;
    endfunction

    localparam int TOTAL = off_at(L);

    generate
        if ((DATA_W < 2) || ((DATA_W % CHUNK_W) != 0)) begin : g_bad_cfg
            $error("bit_population_counter_pipe: DATA_W must be >= 2 and a multiple of CHUNK_W");
        end
    endgenerate

    // All levels share one flat array; every entry is CNT_W wide, which can
    // hold any partial sum up to DATA_W, so no level can overflow.
    logic [CNT_W-1:0]  tree_reg  [TOTAL];
    logic [CNT_W-1:0]  tree_next [TOTAL];
    logic [TOTAL-1:0]  ent_en;
    logic [L-1:0]      val_reg;
    logic [L:0]        ready;
    logic [DATA_W-1:0] src_word;

    assign src_word = mode_i ? ~data_i : data_i;

    generate
        genvar gi, gj;

        // Stage 0: per-chunk bit count of the (optionally inverted) input word.
        for (gi = 0; gi < N_CHUNK; gi++) begin : g_chunk
            logic [CNT_W-1:0] chunk_cnt;

            // Count set bits within this slice.
            always_comb begin
                chunk_cnt = '0;
                for (int b = 0; b < CHUNK_W; b++) begin
                    chunk_cnt = chunk_cnt + CNT_W'(src_word[gi*CHUNK_W + b]);
                end
            end

            assign tree_next[gi] = chunk_cnt;
        end

        // Stages 1..TREE_LVL: pairwise add; an unpaired last entry passes through.
        for (gi = 1; gi <= TREE_LVL; gi++) begin : g_lvl
            for (gj = 0; gj < n_at(gi); gj++) begin : g_ent
                localparam int SRC = off_at(gi - 1) + 2*gj;
                if (2*gj + 1 < n_at(gi - 1)) begin : g_pair
                    assign tree_next[off_at(gi) + gj] = tree_reg[SRC] + tree_reg[SRC + 1];
                end else begin : g_pass
                    assign tree_next[off_at(gi) + gj] = tree_reg[SRC];
                end
            end
        end

        // Each entry loads whenever its stage is ready.
        for (gi = 0; gi < L; gi++) begin : g_en
            for (gj = 0; gj < n_at(gi); gj++) begin : g_ent
                assign ent_en[off_at(gi) + gj] = ready[gi];
            end
        end
    endgenerate

    // Backward ready chain: a stage can load if it is empty or its successor moves.
    always_comb begin
        ready    = '0;
        ready[L] = data_ready_i;
        for (int k = L - 1; k >= 0; k--) begin
            ready[k] = !val_reg[k] || ready[k+1];
        end
    end

    // Stage valid flags advance wherever the stage is ready.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            val_reg <= '0;
        end else begin
            if (ready[0]) val_reg[0] <= data_val_i;
            for (int k = 1; k < L; k++) begin
                if (ready[k]) val_reg[k] <= val_reg[k-1];
            end
        end
    end

    // Count registers; a stalled stage keeps its contents unchanged.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int e = 0; e < TOTAL; e++) tree_reg[e] <= '0;
        end else begin
            for (int e = 0; e < TOTAL; e++) begin
                if (ent_en[e]) tree_reg[e] <= tree_next[e];
            end
        end
    end

    assign data_ready_o = ready[0];
    assign data_o       = tree_reg[TOTAL-1];
    assign data_val_o   = val_reg[L-1];

`ifdef BPC_STATS_EN
    logic [31:0]      stat_beats_reg;
    logic [CNT_W-1:0] stat_max_reg;

    // Transfer count (saturating) and running maximum of transferred results.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            stat_beats_reg <= '0;
            stat_max_reg   <= '0;
        end else if (data_val_o && data_ready_i) begin
            if (stat_beats_reg != '1) stat_beats_reg <= stat_beats_reg + 32'd1;
            if (data_o > stat_max_reg) stat_max_reg <= data_o;
        end
    end

    assign stat_beats_o = stat_beats_reg;
    assign stat_max_o   = stat_max_reg;
`endif

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Testbench for bit_population_counter_pipe: directed latency/boundary beats,
// backpressure, mid-stream reset and random valid/ready traffic checked
// against a queue-based reference model built on $countones.
module tb_bit_population_counter_pipe;

    logic        clk = 1'b0;
    logic        arst_i;
    logic [15:0] data_i;
    logic        mode_i;
    logic        data_val_i;
    logic        data_ready_o;
    logic [4:0]  data_o;
    logic        data_val_o;
    logic        data_ready_i;

    logic [11:0] data12;
    logic        mode12;
    logic        val12;
    logic        ready_o12;
    logic [3:0]  out12;
    logic        val_o12;
    logic        ready_i12;

`ifdef BPC_STATS_EN
    logic [31:0] stat_beats;
    logic [4:0]  stat_max;
    logic [31:0] stat_beats12;
    logic [3:0]  stat_max12;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    bit_population_counter_pipe #(.DATA_W(16), .CHUNK_W(4)) dut (
        .clk_i(clk), .arst_i(arst_i), .data_i(data_i), .mode_i(mode_i),
        .data_val_i(data_val_i), .data_ready_o(data_ready_o), .data_o(data_o),
        .data_val_o(data_val_o), .data_ready_i(data_ready_i)
`ifdef BPC_STATS_EN
        , .stat_beats_o(stat_beats), .stat_max_o(stat_max)
`endif
    );

    bit_population_counter_pipe #(.DATA_W(12), .CHUNK_W(4)) dut12 (
        .clk_i(clk), .arst_i(arst_i), .data_i(data12), .mode_i(mode12),
        .data_val_i(val12), .data_ready_o(ready_o12), .data_o(out12),
        .data_val_o(val_o12), .data_ready_i(ready_i12)
`ifdef BPC_STATS_EN
        , .stat_beats_o(stat_beats12), .stat_max_o(stat_max12)
`endif
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic int ref_count(input logic [15:0] d, input logic m);
        return m ? 16 - $countones(d) : $countones(d);
    endfunction

    // Advance one cycle; report whether the input beat was accepted at this edge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = data_val_i && data_ready_o;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic m, input logic v);
        data_i     = d;
        mode_i     = m;
        data_val_i = v;
    endtask

    // Scoreboard: pop on output transfer, push on input accept.
    always @(negedge clk) begin
        if (!arst_i) begin
            if (data_val_o && data_ready_i) begin
                n_xfer++;
                if (exp_q.size() == 0) chk("stale_out", data_val_o, 0);
                else chk("out_order", data_o, exp_q.pop_front());
            end
            if (data_val_i && data_ready_o) exp_q.push_back(ref_count(data_i, mode_i));
        end
    end

    logic [15:0] sb_data [5] = '{16'hFFFF, 16'h00F0, 16'h0000, 16'h0000, 16'hFFFF};
    logic        sb_mode [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] st_data [4] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
    logic [11:0] w12_data [3] = '{12'hFFF, 12'h801, 12'h801};
    logic        w12_mode [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] bp_data [10];

    task automatic random_phase(input int cycles);
        bit acc;
        for (int c = 0; c < cycles; c++) begin
            drive(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            data_ready_i = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        data_val_i   = 1'b0;
        data_ready_i = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) step(acc);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        int idx;
        int base;
        int exp12;

        arst_i = 1'b1;
        drive(16'h0, 1'b0, 1'b0);
        data_ready_i = 1'b1;
        data12 = '0; mode12 = 1'b0; val12 = 1'b0; ready_i12 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_val_o", data_val_o, 0);
        chk("rst_data_o", data_o, 0);
        #3 arst_i = 1'b0;
        #1 chk("rst_ready_o", data_ready_o, 1);
        @(posedge clk); #1;

`ifdef BPC_STATS_EN
        drive(16'h001F, 1'b0, 1'b1); step(acc);
        drive(16'hFFFF, 1'b0, 1'b1); step(acc);
        drive(16'h0007, 1'b0, 1'b1); step(acc);
        data_val_i = 1'b0;
        repeat (5) step(acc);
        chk("stat_beats", stat_beats, 3);
        chk("stat_max", stat_max, 16);
        #2 arst_i = 1'b1;
        #1 chk("stat_beats_rst", stat_beats, 0);
        chk("stat_max_rst", stat_max, 0);
        @(posedge clk); #2 arst_i = 1'b0;
        @(posedge clk); #1;
`endif

        // Single beats: L = 3 cycle latency and boundary counts.
        for (int i = 0; i < 5; i++) begin
            drive(sb_data[i], sb_mode[i], 1'b1);
            step(acc);
            chk("single_acc", acc, 1);
            data_val_i = 1'b0;
            chk("lat_edge0", data_val_o, 0);
            step(acc);
            chk("lat_edge1", data_val_o, 0);
            step(acc);
            chk("lat_edge2_val", data_val_o, 1);
            chk("single_data", data_o, ref_count(sb_data[i], sb_mode[i]));
            step(acc);
            step(acc);
        end

        // Back-to-back streaming: results on consecutive cycles.
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(st_data[k], 1'b0, 1'b1);
            else data_val_i = 1'b0;
            step(acc);
            if (k >= 2) begin
                chk("stream_val", data_val_o, 1);
                chk("stream_data", data_o, k - 1);
            end
        end
        repeat (3) step(acc);

        // Backpressure: 6 stalled cycles accept exactly 3 beats and hold the head.
        for (int i = 0; i < 10; i++) bp_data[i] = 16'($urandom);
        base = n_xfer;
        idx = 0;
        data_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(bp_data[idx], 1'b0, 1'b1);
            step(acc);
            if (acc) idx++;
            if (c >= 2) begin
                chk("bp_hold_val", data_val_o, 1);
                chk("bp_hold_data", data_o, ref_count(bp_data[0], 1'b0));
            end
        end
        chk("bp_accepted", idx, 3);
        chk("bp_ready_low", data_ready_o, 0);
        data_ready_i = 1'b1;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            drive(bp_data[idx], 1'b0, 1'b1);
            step(acc);
            if (acc) idx++;
        end
        data_val_i = 1'b0;
        chk("bp_all_in", idx, 10);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(acc);
        chk("bp_xfer", n_xfer - base, 10);

        // Random valid/ready traffic against the scoreboard.
        random_phase(400);

        // Mid-stream reset with 3 beats in flight.
        data_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'($urandom | 1), 1'b0, 1'b1);
            step(acc);
        end
        data_val_i = 1'b0;
        chk("pre_rst_full_val", data_val_o, 1);
        #2 arst_i = 1'b1;
        #1 chk("mid_rst_val_o", data_val_o, 0);
        chk("mid_rst_data_o", data_o, 0);
        exp_q.delete();
        @(posedge clk); #3 arst_i = 1'b0;
        #1 chk("post_rst_ready", data_ready_o, 1);
        data_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(acc);
            chk("post_rst_quiet", data_val_o, 0);
        end
        random_phase(200);

        // 12-bit instance: three chunks, odd entry passes through the tree.
        for (int i = 0; i < 3; i++) begin
            exp12 = w12_mode[i] ? 12 - $countones(w12_data[i]) : $countones(w12_data[i]);
            data12 = w12_data[i];
            mode12 = w12_mode[i];
            val12  = 1'b1;
            @(posedge clk); #1;
            val12 = 1'b0;
            @(posedge clk); #1;
            chk("w12_lat1", val_o12, 0);
            @(posedge clk); #1;
            chk("w12_val", val_o12, 1);
            chk("w12_data", out12, exp12);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
